// File: rtl/muldiv_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply,
// restoring divide with signed fix-up, and HI/LO registers behind a start/ready/done handshake.
module muldiv_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_e;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
  } op_e;

  state_e state, state_next;
  op_e    opc;

  // acc/sr hold {product high, product low} for MUL and {remainder, quotient} for DIV
  logic [WIDTH-1:0]   acc, sr, dvs;
  logic [CW-1:0]      cnt;
  logic               neg_main, neg_rem, was_div;

  logic               go_mul, go_div, sgn, dbz_now;
  logic [WIDTH-1:0]   mag_a, mag_b, alu_res;
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (go_mul) state_next = MUL;
            else if (go_div) state_next = DIV;
      MUL, DIV: if (cnt == CW'(1)) state_next = FIN;
      FIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    opc     = op_e'(op);
    ready   = (state == IDLE);
    sgn     = (opc == OP_MULT) || (opc == OP_DIV);
    dbz_now = ((opc == OP_DIV) || (opc == OP_DIVU)) && (b == '0);
    go_mul  = start && ready && ((opc == OP_MULT) || (opc == OP_MULTU));
    go_div  = start && ready && ((opc == OP_DIV) || (opc == OP_DIVU)) && !dbz_now;
    mag_a   = (sgn && a[WIDTH-1]) ? -a : a;
    mag_b   = (sgn && b[WIDTH-1]) ? -b : b;

    alu_res = '0;
    case (opc)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_res = WIDTH'(a < b);
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      OP_MTHI: alu_res = a;
      OP_MTLO: alu_res = a;
      default: alu_res = '0;
    endcase

    mul_sum   = {1'b0, acc} + (sr[0] ? {1'b0, dvs} : '0);
    div_trial = {acc, sr[WIDTH-1]};
    div_diff  = div_trial - {1'b0, dvs};
    prod_fix  = neg_main ? -{acc, sr} : {acc, sr};
    quo_fix   = neg_main ? -sr : sr;
    rem_fix   = neg_rem ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0; sr <= '0; dvs <= '0; cnt <= '0;
      neg_main <= 1'b0; neg_rem <= 1'b0; was_div <= 1'b0;
      hi <= '0; lo <= '0; result <= '0;
      zero <= 1'b1; done <= 1'b0; div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (go_mul || go_div) begin
            acc      <= '0;
            sr       <= mag_a;
            dvs      <= mag_b;
            cnt      <= CW'(WIDTH);
            neg_main <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= sgn && a[WIDTH-1];
            was_div  <= go_div;
          end else begin
            result      <= alu_res;
            zero        <= (alu_res == '0);
            done        <= 1'b1;
            div_by_zero <= dbz_now;
            if (opc == OP_MTHI) hi <= a;
            if (opc == OP_MTLO) lo <= a;
          end
        end
        MUL: begin
          {acc, sr} <= {mul_sum, sr[WIDTH-1:1]};
          cnt       <= cnt - CW'(1);
        end
        DIV: begin
          // trial subtraction never underflows past bit WIDTH since acc < dvs
          acc <= div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0];
          sr  <= {sr[WIDTH-2:0], ~div_diff[WIDTH]};
          cnt <= cnt - CW'(1);
        end
        FIN: begin
          done        <= 1'b1;
          div_by_zero <= 1'b0;
          if (was_div) begin
            lo <= quo_fix; hi <= rem_fix;
            result <= quo_fix; zero <= (quo_fix == '0);
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH]; lo <= prod_fix[WIDTH-1:0];
            result <= prod_fix[WIDTH-1:0]; zero <= (prod_fix[WIDTH-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_alu.sv
// Scoreboard bench for muldiv_alu (WIDTH=32): a reference model pushes expected
// results at issue time; each scenario task pops and compares when done pulses.
module tb_muldiv_alu;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [4:0]  op, shamt;
  logic [31:0] a, b;
  logic        ready, done, zero, div_by_zero;
  logic [31:0] result, hi, lo;

  typedef struct packed {
    logic [31:0] res;
    logic        zr;
    logic [31:0] h;
    logic [31:0] l;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] hi_m, lo_m;
  int          n_cmp = 0;
  int          n_err = 0;

  muldiv_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
    .ready(ready), .done(done), .result(result), .zero(zero),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] s);
    exp_t      t;
    logic [63:0] p;
    longint    qa, qb, q, rm;
    t.res = '0; t.dbz = 1'b0;
    case (o)
      5'd0:  t.res = x + y;
      5'd1:  t.res = x - y;
      5'd2:  t.res = x & y;
      5'd3:  t.res = x | y;
      5'd4:  t.res = ~(x | y);
      5'd5:  t.res = x ^ y;
      5'd6:  t.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      5'd7:  t.res = (x < y) ? 32'd1 : 32'd0;
      5'd8:  t.res = y << s;
      5'd9:  t.res = y >> s;
      5'd10: t.res = $signed(y) >>> s;
      5'd11: begin
        p = longint'($signed(x)) * longint'($signed(y));
        hi_m = p[63:32]; lo_m = p[31:0]; t.res = lo_m;
      end
      5'd12: begin
        p = {32'd0, x} * {32'd0, y};
        hi_m = p[63:32]; lo_m = p[31:0]; t.res = lo_m;
      end
      5'd13, 5'd14: begin
        if (y == 32'd0) t.dbz = 1'b1;
        else begin
          if (o == 5'd13) begin qa = longint'($signed(x)); qb = longint'($signed(y)); end
          else            begin qa = longint'({32'd0, x}); qb = longint'({32'd0, y}); end
          q = qa / qb; rm = qa % qb;
          lo_m = q[31:0]; hi_m = rm[31:0]; t.res = lo_m;
        end
      end
      5'd15: t.res = hi_m;
      5'd16: t.res = lo_m;
      5'd17: begin hi_m = x; t.res = x; end
      5'd18: begin lo_m = x; t.res = x; end
      default: t.res = '0;
    endcase
    t.zr = (t.res == 32'd0);
    t.h = hi_m; t.l = lo_m;
    sb.push_back(t);
  endtask

  // Drives one start pulse (called #1 after an edge) and returns #1 after the accept edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s);
    op = o; a = x; b = y; shamt = s; start = 1'b1;
    push_exp(o, x, y, s);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit got);
    cycles = 0; got = 1'b0;
    while (cycles < budget && !got) begin
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ready, done, zero, div_by_zero} !== 4'b1010) begin
      n_err++; $display("FAIL reset_flags: ready/done/zero/dbz=%b required 1010", {ready, done, zero, div_by_zero});
    end
    n_cmp++;
    if ({result, hi, lo} !== 96'd0) begin
      n_err++; $display("FAIL reset_regs: result=%h hi=%h lo=%h required all 0", result, hi, lo);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_cycle;
    logic [4:0]  ops [12] = '{5'd1, 5'd6, 5'd7, 5'd10, 5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd25};
    logic [31:0] as  [12] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hF0F0F0F0,
                              32'hF0F0F0F0, 32'h0000FFFF, 32'hAAAA5555, 32'd0, 32'd0, 32'h12345678};
    logic [31:0] bs  [12] = '{32'd7, 32'd1, 32'd1, 32'h80000000, 32'd1, 32'h0FF00FF0,
                              32'h0F0F0F0F, 32'h00FF0000, 32'hFFFF0000, 32'h00000003, 32'h80000000, 32'd9};
    logic [4:0]  ss  [12] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd0};
    logic [31:0] held;
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], as[i], bs[i], ss[i]);
      n_cmp++;
      if ({done, ready} !== 2'b11) begin
        n_err++; $display("FAIL single_handshake[%0d]: done/ready=%b required 11", i, {done, ready});
      end
      if (sb.size() == 0) begin
        n_cmp++; n_err++; $display("FAIL single_sb[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if ({result, zero, hi, lo, div_by_zero} !== e) begin
          n_err++;
          $display("FAIL single_op[%0d] op=%0d: result=%h zero=%b hi=%h lo=%h dbz=%b required result=%h zero=%b hi=%h lo=%h dbz=%b",
                   i, ops[i], result, zero, hi, lo, div_by_zero, e.res, e.zr, e.h, e.l, e.dbz);
        end
      end
    end
    held = result;
    @(posedge clk); #1;
    n_cmp++;
    if ({done, result} !== {1'b0, held}) begin
      n_err++; $display("FAIL idle_hold: done=%b result=%h required done=0 result=%h", done, result, held);
    end
  endtask

  task automatic test_muldiv(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                             input bool_follow_mfhi);
    int cyc;
    bit got;
    issue(o, x, y, 5'd0);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++; $display("FAIL busy_ready op=%0d: ready=%b required 0", o, ready);
    end
    wait_done(40, cyc, got);
    n_cmp++;
    if (!got || cyc != 33) begin
      n_err++; $display("FAIL latency op=%0d: done seen=%0d after %0d cycles required 33", o, got, cyc);
    end
    if (sb.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL muldiv_sb op=%0d: scoreboard empty", o);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({result, zero, hi, lo, div_by_zero, ready} !== {e, 1'b1}) begin
        n_err++;
        $display("FAIL muldiv op=%0d a=%h b=%h: result=%h hi=%h lo=%h dbz=%b ready=%b required result=%h hi=%h lo=%h dbz=%b ready=1",
                 o, x, y, result, hi, lo, div_by_zero, ready, e.res, e.h, e.l, e.dbz);
      end
    end
    if (bool_follow_mfhi) begin
      issue(5'd15, 32'd0, 32'd0, 5'd0);
      e = sb.pop_front();
      n_cmp++;
      if ({done, result} !== {1'b1, e.res}) begin
        n_err++; $display("FAIL mfhi_after: done=%b result=%h required done=1 result=%h", done, result, e.res);
      end
    end
  endtask

  task automatic test_div_zero;
    issue(5'd17, 32'h55, 32'd0, 5'd0);
    e = sb.pop_front();
    n_cmp++;
    if ({done, hi} !== {1'b1, e.h}) begin
      n_err++; $display("FAIL mthi: done=%b hi=%h required done=1 hi=%h", done, hi, e.h);
    end
    issue(5'd13, 32'd9, 32'd0, 5'd0);
    e = sb.pop_front();
    n_cmp++;
    if ({done, ready, result, zero, hi, lo, div_by_zero} !== {1'b1, 1'b1, e}) begin
      n_err++;
      $display("FAIL div_zero: done=%b ready=%b result=%h zero=%b hi=%h lo=%h dbz=%b required 1 1 %h %b %h %h %b",
               done, ready, result, zero, hi, lo, div_by_zero, e.res, e.zr, e.h, e.l, e.dbz);
    end
    issue(5'd0, 32'd2, 32'd3, 5'd0);
    e = sb.pop_front();
    n_cmp++;
    if ({done, result, div_by_zero} !== {1'b1, e.res, 1'b0}) begin
      n_err++; $display("FAIL dbz_clear: done=%b result=%h dbz=%b required 1 %h 0", done, result, div_by_zero, e.res);
    end
  endtask

  task automatic test_start_toggle;
    int cyc;
    int ndone;
    issue(5'd12, 32'h0001_2345, 32'h0000_1010, 5'd0);
    op = 5'd0; a = 32'd1; b = 32'd1;
    cyc = 0; ndone = 0;
    while (cyc < 40 && ndone == 0) begin
      start = ~start;
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    n_cmp++;
    if (ndone != 1 || cyc != 33) begin
      n_err++; $display("FAIL toggle_done: dones=%0d at cycle %0d required 1 at 33", ndone, cyc);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({result, hi, lo} !== {e.res, e.h, e.l}) begin
      n_err++; $display("FAIL toggle_product: result=%h hi=%h lo=%h required %h %h %h", result, hi, lo, e.res, e.h, e.l);
    end
    issue(5'd16, 32'd0, 32'd0, 5'd0);
    e = sb.pop_front();
    n_cmp++;
    if ({done, result} !== {1'b1, e.res}) begin
      n_err++; $display("FAIL mflo_after: done=%b result=%h required done=1 result=%h", done, result, e.res);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL toggle_extra_done: done=%b required 0", done);
    end
  endtask

  task automatic test_reset_mid_div;
    int ndone;
    issue(5'd13, 32'd1000, 32'd7, 5'd0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    hi_m = '0; lo_m = '0;
    n_cmp++;
    if ({ready, done, zero, result, hi, lo} !== {3'b101, 96'd0}) begin
      n_err++;
      $display("FAIL reset_mid_div: ready=%b done=%b zero=%b result=%h hi=%h lo=%h required 1 0 1 0 0 0",
               ready, done, zero, result, hi, lo);
    end
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_err++; $display("FAIL aborted_done: dones=%0d required 0", ndone);
    end
  endtask

  initial begin
    test_reset;
    test_single_cycle;
    test_muldiv(5'd11, 32'hFFFFFFFE, 32'd3, 1'b1);
    test_muldiv(5'd12, 32'hFFFFFFFE, 32'd3, 1'b1);
    test_muldiv(5'd11, 32'h7FFFFFFF, 32'h80000000, 1'b0);
    test_muldiv(5'd13, 32'hFFFFFFF9, 32'd2, 1'b1);
    test_muldiv(5'd14, 32'd7, 32'd2, 1'b0);
    test_muldiv(5'd13, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    test_muldiv(5'd13, 32'd7, 32'hFFFFFFFE, 1'b0);
    test_muldiv(5'd14, 32'hFFFFFFFF, 32'd10, 1'b0);
    test_div_zero;
    test_start_toggle;
    test_reset_mid_div;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
